// File: rtl/main_mem_responder.sv
// main_mem_responder
//
// Memory-side responder for a cache memory port. A rising edge on wr_mem
// or rd_mem, sampled while idle, starts a block transaction. ready_mem is
// held low for LATENCY wait cycles plus a four-beat byte burst. Beats are
// transferred in offset order 0..3 over the shared data_mem bus.
//
// Ports
//   clock      single clock, all state on the rising edge
//   reset_n    asynchronous active-low reset
//   addr_mem   byte address; only bits [MEM_AW-1:2] select the block
//   rd_mem     block read request (level, rising edge starts a fill)
//   wr_mem     block write request (level, rising edge starts a write-back)
//   data_mem   bidirectional byte bus, driven here only during read beats
//   ready_mem  1 = idle and ready for a request, 0 = transaction busy
//
// The storage array is not cleared by reset.

module main_mem_responder #(
    parameter int MEM_AW  = 10,
    parameter int LATENCY = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] addr_mem,
    input  logic        rd_mem,
    input  logic        wr_mem,
    inout  wire  [7:0]  data_mem,
    output logic        ready_mem
);

    localparam int         DEPTH    = 1 << MEM_AW;
    localparam int         BW       = MEM_AW - 2;
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RBURST = 2'd2,
        ST_WBURST = 2'd3
    } state_t;

    state_t        state_r,    state_s;
    logic [3:0]    wait_cnt_r, wait_cnt_s;
    logic [1:0]    beat_r,     beat_s;
    logic [BW-1:0] base_r,     base_s;
    logic          dir_wr_r,   dir_wr_s;
    logic          rd_prev_r,  wr_prev_r;
    logic          rd_edge_s,  wr_edge_s;
    logic          ready_r;
    logic          drive_r;
    logic [7:0]    dout_r;
    logic [7:0]    mem_r [DEPTH];

    // Upper address bits alias and the byte offset is ignored; this
    // collects them so their non-use is explicit.
    logic          addr_unused_s;
    assign addr_unused_s = ^{addr_mem[15:MEM_AW], addr_mem[1:0]};

    // A request is a 1 now that was 0 at the previous sampled edge.
    assign rd_edge_s = rd_mem & ~rd_prev_r;
    assign wr_edge_s = wr_mem & ~wr_prev_r;

    assign ready_mem = ready_r;
    assign data_mem  = drive_r ? dout_r : 8'hzz;

    // Next-state logic: accept in IDLE, count down the latency, then four beats.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        beat_s     = beat_r;
        base_s     = base_r;
        dir_wr_s   = dir_wr_r;
        case (state_r)
            ST_IDLE: begin
                // Write wins a tie so the write-back lands before the fill.
                if (wr_edge_s) begin
                    state_s    = ST_WAIT;
                    wait_cnt_s = LAT_LOAD;
                    beat_s     = 2'd0;
                    base_s     = addr_mem[MEM_AW-1:2];
                    dir_wr_s   = 1'b1;
                end else if (rd_edge_s) begin
                    state_s    = ST_WAIT;
                    wait_cnt_s = LAT_LOAD;
                    beat_s     = 2'd0;
                    base_s     = addr_mem[MEM_AW-1:2];
                    dir_wr_s   = 1'b0;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    state_s = dir_wr_r ? ST_WBURST : ST_RBURST;
                    beat_s  = 2'd0;
                end else begin
                    wait_cnt_s = wait_cnt_r - 4'd1;
                end
            end
            ST_RBURST, ST_WBURST: begin
                if (beat_r == 2'd3) begin
                    state_s = ST_IDLE;
                    beat_s  = 2'd0;
                end else begin
                    beat_s  = beat_r + 2'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control registers plus registered bus-drive and ready outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
            beat_r     <= 2'd0;
            base_r     <= '0;
            dir_wr_r   <= 1'b0;
            rd_prev_r  <= 1'b0;
            wr_prev_r  <= 1'b0;
            ready_r    <= 1'b1;
            drive_r    <= 1'b0;
            dout_r     <= 8'h00;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            beat_r     <= beat_s;
            base_r     <= base_s;
            dir_wr_r   <= dir_wr_s;
            rd_prev_r  <= rd_mem;
            wr_prev_r  <= wr_mem;
            ready_r    <= (state_s == ST_IDLE);
            drive_r    <= (state_s == ST_RBURST);
            // Fetch the byte for the beat about to be driven; the beat
            // only touches the low two address bits.
            dout_r     <= mem_r[{base_s, beat_s}];
        end
    end

    // Storage write: each write-burst edge captures the cache's byte.
    always_ff @(posedge clock) begin
        if (state_r == ST_WBURST) begin
            mem_r[{base_r, beat_r}] <= data_mem;
        end
    end

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder. Two instances (LATENCY 4 and
// LATENCY 1) share the request inputs but each has its own data bus. A
// transaction-level model predicts ready_mem and the bus value for every
// cycle; the expectation is queued by the stimulus and popped by a monitor.
// Undriven buses are pulled high, so an idle bus reads 8'hFF.

module tb_main_mem_responder;

    typedef struct {
        logic       ready;
        logic [7:0] bus;
        bit         chk_bus;
        int         edge_no;
    } exp_t;

    logic        clock    = 1'b0;
    logic        reset_n  = 1'b0;
    logic [15:0] addr_mem = 16'h0000;
    logic        rd_mem   = 1'b0;
    logic        wr_mem   = 1'b0;
    logic        ready0, ready1;
    wire  [7:0]  bus0, bus1;
    logic [7:0]  drv_val0 = 8'h00;
    logic [7:0]  drv_val1 = 8'h00;
    logic        drv_en0  = 1'b0;
    logic        drv_en1  = 1'b0;

    assign bus0 = drv_en0 ? drv_val0 : 8'hzz;
    assign bus1 = drv_en1 ? drv_val1 : 8'hzz;
    pullup (bus0);
    pullup (bus1);

    main_mem_responder #(.MEM_AW(10), .LATENCY(4)) dut0 (
        .clock(clock), .reset_n(reset_n), .addr_mem(addr_mem),
        .rd_mem(rd_mem), .wr_mem(wr_mem), .data_mem(bus0), .ready_mem(ready0));

    main_mem_responder #(.MEM_AW(10), .LATENCY(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .addr_mem(addr_mem),
        .rd_mem(rd_mem), .wr_mem(wr_mem), .data_mem(bus1), .ready_mem(ready1));

    always #5 clock = ~clock;

    // Reference model state, one slot per instance.
    int          lat [2] = '{4, 1};
    bit          busy [2];
    bit          is_wr [2];
    bit          prev_rd [2];
    bit          prev_wr [2];
    int          k_edge [2];
    int          base [2];
    logic [7:0]  wdata [2][4];
    logic [7:0]  ref_mem [2][1024];
    bit          known [2][1024];
    logic [7:0]  next_wdata [4];
    int          ecnt = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic accept(input int d, input bit w);
        busy[d]   = 1'b1;
        is_wr[d]  = w;
        k_edge[d] = ecnt;
        base[d]   = int'(addr_mem[9:2]);
        for (int i = 0; i < 4; i++) wdata[d][i] = next_wdata[i];
    endtask

    // Effect of one rising edge on instance d, from the timing rules.
    task automatic model_edge(input int d);
        int off;
        if (!reset_n) begin
            busy[d] = 1'b0; prev_rd[d] = 1'b0; prev_wr[d] = 1'b0;
        end else begin
            if (busy[d]) begin
                off = ecnt - k_edge[d];
                if (is_wr[d] && off >= lat[d] + 1 && off <= lat[d] + 4) begin
                    ref_mem[d][base[d]*4 + off - lat[d] - 1] = wdata[d][off - lat[d] - 1];
                    known[d][base[d]*4 + off - lat[d] - 1]   = 1'b1;
                end
                if (off == lat[d] + 4) busy[d] = 1'b0;
            end else if (wr_mem && !prev_wr[d]) begin
                accept(d, 1'b1);
            end else if (rd_mem && !prev_rd[d]) begin
                accept(d, 1'b0);
            end
            prev_rd[d] = rd_mem;
            prev_wr[d] = wr_mem;
        end
    endtask

    // Expected outputs for the cycle after the current edge; also drives write beats.
    task automatic model_out(input int d);
        exp_t x;
        int   off;
        bit   den;
        logic [7:0] dval;
        x.ready = 1'b1; x.bus = 8'hFF; x.chk_bus = 1'b1; x.edge_no = ecnt;
        den = 1'b0; dval = 8'h00;
        if (busy[d]) begin
            x.ready = 1'b0;
            off = ecnt - k_edge[d];
            if (off >= lat[d] && off <= lat[d] + 3) begin
                if (is_wr[d]) begin
                    den = 1'b1; dval = wdata[d][off - lat[d]]; x.bus = dval;
                end else begin
                    x.bus     = ref_mem[d][base[d]*4 + off - lat[d]];
                    x.chk_bus = known[d][base[d]*4 + off - lat[d]];
                end
            end
        end
        if (d == 0) begin
            drv_en0 = den; drv_val0 = dval; q0.push_back(x);
        end else begin
            drv_en1 = den; drv_val1 = dval; q1.push_back(x);
        end
    endtask

    task automatic step(input bit rst_pulse);
        @(posedge clock);
        #1;
        ecnt++;
        model_edge(0);
        model_edge(1);
        if (!reset_n) reset_n = 1'b1;
        if (rst_pulse) begin
            reset_n = 1'b0;
            for (int d = 0; d < 2; d++) begin
                busy[d] = 1'b0; prev_rd[d] = 1'b0; prev_wr[d] = 1'b0;
            end
        end
        model_out(0);
        model_out(1);
    endtask

    task automatic set_data(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        next_wdata[0] = b0; next_wdata[1] = b1; next_wdata[2] = b2; next_wdata[3] = b3;
    endtask

    // One request edge, then drop the request and let both instances finish.
    task automatic issue(input bit rd, input bit wr, input logic [15:0] a);
        addr_mem = a; rd_mem = rd; wr_mem = wr;
        step(1'b0);
        rd_mem = 1'b0; wr_mem = 1'b0;
        repeat (10) step(1'b0);
    endtask

    // Monitor: compare every cycle's outputs against the queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(negedge clock);
            if (q0.size() > 0) begin
                x = q0.pop_front();
                check($sformatf("dut0 ready e%0d", x.edge_no), {7'd0, ready0}, {7'd0, x.ready});
                if (x.chk_bus) check($sformatf("dut0 bus e%0d", x.edge_no), bus0, x.bus);
            end
            if (q1.size() > 0) begin
                x = q1.pop_front();
                check($sformatf("dut1 ready e%0d", x.edge_no), {7'd0, ready1}, {7'd0, x.ready});
                if (x.chk_bus) check($sformatf("dut1 bus e%0d", x.edge_no), bus1, x.bus);
            end
        end
    end

    initial begin
        set_data(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (2) step(1'b0);

        // Write then read back, offset bits ignored.
        set_data(8'h11, 8'h22, 8'h33, 8'h44);
        issue(1'b0, 1'b1, 16'h008B);
        issue(1'b1, 1'b0, 16'h0089);

        // Upper address bits alias onto the same block.
        set_data(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        issue(1'b0, 1'b1, 16'hC08B);
        issue(1'b1, 1'b0, 16'h008B);

        // Simultaneous rd and wr edges: only the write happens.
        set_data(8'h5A, 8'hA5, 8'h3C, 8'hC3);
        issue(1'b1, 1'b1, 16'h0100);
        issue(1'b1, 1'b0, 16'h0100);

        // Read edge while busy is ignored.
        addr_mem = 16'h008B; rd_mem = 1'b1; step(1'b0);
        rd_mem = 1'b0; step(1'b0);
        rd_mem = 1'b1; step(1'b0);
        rd_mem = 1'b0; repeat (12) step(1'b0);

        // Held request gives a single transaction; a new edge gives another.
        addr_mem = 16'h0089; rd_mem = 1'b1;
        repeat (20) step(1'b0);
        rd_mem = 1'b0; repeat (3) step(1'b0);
        issue(1'b1, 1'b0, 16'h0089);

        // Reset after beat 1 of a write leaves bytes 2 and 3 untouched.
        set_data(8'h00, 8'h00, 8'h00, 8'h00);
        issue(1'b0, 1'b1, 16'h0010);
        set_data(8'h55, 8'h66, 8'h77, 8'h88);
        addr_mem = 16'h0010; wr_mem = 1'b1; step(1'b0);
        wr_mem = 1'b0; repeat (5) step(1'b0);
        step(1'b1);
        repeat (3) step(1'b0);
        issue(1'b1, 1'b0, 16'h0010);

        // Request held across reset release counts as an edge.
        addr_mem = 16'h0010; rd_mem = 1'b1; step(1'b1);
        repeat (12) step(1'b0);
        rd_mem = 1'b0; repeat (2) step(1'b0);

        // Randomized traffic over 16 blocks with aliased upper bits.
        for (int n = 0; n < 600; n++) begin
            addr_mem = 16'($urandom) & 16'hFC3F;
            rd_mem   = ($urandom_range(0, 2) == 0);
            wr_mem   = ($urandom_range(0, 3) == 0);
            set_data(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            step(1'b0);
        end
        rd_mem = 1'b0; wr_mem = 1'b0;
        repeat (10) step(1'b0);

        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/main_mem_responder.md
# main_mem_responder

Memory-side responder for the cache's memory port. Accepts block read (line fill) and block write (write-back) requests from the 2-way set-associative cache controller. Holds `ready_mem` low for a fixed access latency, then transfers a 4-byte block one byte per cycle over the shared bidirectional `data_mem` bus. It is synthesizable and serves as the main-memory model in cache-level simulation.

## Interface
- `MEM_AW`, 10: byte-address width of internal storage (2^MEM_AW bytes); `addr_mem[15:MEM_AW]` ignored (aliasing).
- `LATENCY`, 4: wait cycles between request accept and first data beat; legal 1..15.
- `clock`  in  1  single clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `addr_mem`  in  16  byte address from cache; bits [1:0] ignored, block base = {addr_mem[MEM_AW-1:2],2'b00}.
- `rd_mem`  in  1  block read request (level, rising edge starts transaction).
- `wr_mem`  in  1  block write request (level, rising edge starts transaction).
- `data_mem`  inout  8  shared data bus; driven by this block only during read beats, Z otherwise.
- `ready_mem`  out  1  1 = idle/ready for a request, 0 = transaction in progress.

## Operation
- Storage: byte array, 2^MEM_AW entries, not cleared by reset.
- Request detect: registered `rd_q`/`wr_q` hold previous-cycle `rd_mem`/`wr_mem`; request = input 1 and registered copy 0, sampled only in IDLE.
- Both rising edges in the same cycle: write accepted, read dropped (write-back precedes fill).
- Rising edge outside IDLE: ignored, no queuing; the cache must wait for `ready_mem`=1.
- On accept: latch block base and direction; request level afterwards is don't-care until IDLE.
- FSM states:
  - IDLE: `ready_mem`=1; rd edge -> WAIT(rd); wr edge -> WAIT(wr).
  - WAIT: down-counter loaded with LATENCY-1; goes to RBURST/WBURST when the count is 0.
  - RBURST: beat counter 0..3; drive `data_mem` = mem[base+beat]; after beat 3 -> IDLE.
  - WBURST: beat counter 0..3; mem[base+beat] <= `data_mem` each edge; after beat 3 -> IDLE.
- Beat order is always offset 0,1,2,3; there is no critical-word-first.
- Address arithmetic: the beat adds only to bits [1:0]. A block never crosses a 4-byte boundary.

## Timing
- Edge k accepts the request: `ready_mem`=0 from just after edge k.
- WAIT occupies cycles after edges k .. k+LATENCY-1.
- Read: beat i is driven in the cycle after edge k+LATENCY+i (i=0..3). The cache samples beat i at edge k+LATENCY+i+1.
- Write: the cache drives beat i in the cycle after edge k+LATENCY+i. The memory samples it at edge k+LATENCY+i+1.
- After edge k+LATENCY+4: IDLE, `ready_mem`=1, `data_mem`=Z.
- Total: `ready_mem` is low for exactly LATENCY+4 cycles.
- Back-to-back: the earliest new accept is at edge k+LATENCY+5. This requires the request to have been 0 at the sample before it, so the cache must drop the request for at least one sampled edge.
- Reset (asserted at any time, including mid-burst):
  - Immediately: IDLE, `ready_mem`=1, `data_mem`=Z, counters 0, `rd_q`=`wr_q`=0.
  - A write aborted by reset leaves already-written bytes updated and the rest unchanged.
- After reset release, a request already held at 1 counts as a rising edge at the first clock edge.
- `data_mem` is never driven during WAIT, WBURST or IDLE. This keeps the bus free of contention with the cache's write drive.

## Test plan
- Write then read, LATENCY=4:
  - Stimulus: wr edge at 0x008B, cache drives 11,22,33,44 on beats 0..3; then rd edge at 0x0089.
  - Required: `ready_mem` low 8 cycles per transaction; read beats return 11,22,33,44 in order, starting exactly 4 cycles after accept.
- Address handling:
  - Stimulus: write AA,BB,CC,DD at 0xC08B with MEM_AW=10, then read 0x008B.
  - Required: returns AA,BB,CC,DD (upper bits aliased, offset ignored).
- Simultaneous and overlapping requests:
  - Stimulus: rd and wr rising in the same cycle.
  - Required: a write transaction occurs, no read beats are driven.
  - Stimulus: rd edge during WAIT.
  - Required: the rd edge is ignored; `ready_mem` returns to 1 after LATENCY+4 cycles and nothing more happens.
- Held request:
  - Stimulus: `rd_mem` held 1 for 20 cycles.
  - Required: exactly one read transaction; a new edge after deassert starts a second.
- Reset mid-write:
  - Stimulus: `reset_n` pulsed low after beat 1 of a write of 55,66,77,88 to block 0x0010 (previously 00s).
  - Required: `ready_mem`=1 and `data_mem`=Z immediately; a later read returns 55,66,00,00.
- LATENCY=1 corner:
  - Stimulus: single read with LATENCY=1.
  - Required: beat 0 is driven in the cycle after edge k+1, `ready_mem` is low for 5 cycles, and `data_mem` is Z in all non-beat cycles.
